alu_system: RTL and testbench

- Datapath of the teaching CPU, with no controller inside.
- Contains: 8-reg general register file (RF), 3-reg address register file (ARF), 16-bit ALU with registered flags, 16-bit instruction register (IR), 64Kx8 memory (MEM), and muxes A/B/C.
- All control comes from external select/enable inputs; the future control unit drives them.

---
 rtl/alu_system_pkg.sv | 55 +++++
 rtl/alu_system_register16.sv | 37 +++
 rtl/alu_system.sv | 189 ++++++++++++++++++
 tb/tb_alu_system.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_system_pkg.sv
// Shared codes for the teaching-CPU datapath: register functions, ALU ops,
// ARF output selects, mux sources and flag bit positions.
package alu_system_pkg;

   // Function applied on the clock edge by every enabled 16-bit register
   typedef enum logic [2:0] {
      FUN_DEC     = 3'b000,
      FUN_INC     = 3'b001,
      FUN_LOAD    = 3'b010,
      FUN_CLR     = 3'b011,
      FUN_LOAD_ZX = 3'b100,
      FUN_LOAD_LO = 3'b101,
      FUN_LOAD_HI = 3'b110,
      FUN_LOAD_SX = 3'b111
   } fun_sel_e;

   // ALU operation, low four bits of ALU_FunSel
   typedef enum logic [3:0] {
      ALU_A     = 4'h0,
      ALU_B     = 4'h1,
      ALU_NOT_A = 4'h2,
      ALU_NOT_B = 4'h3,
      ALU_ADD   = 4'h4,
      ALU_ADC   = 4'h5,
      ALU_SUB   = 4'h6,
      ALU_AND   = 4'h7,
      ALU_OR    = 4'h8,
      ALU_XOR   = 4'h9,
      ALU_NAND  = 4'hA,
      ALU_LSL   = 4'hB,
      ALU_LSR   = 4'hC,
      ALU_ASR   = 4'hD,
      ALU_CSL   = 4'hE,
      ALU_CSR   = 4'hF
   } alu_op_e;

   // ARF output selects (both 00 and 01 give PC)
   localparam logic [1:0] OUT_PC     = 2'b00;
   localparam logic [1:0] OUT_PC_ALT = 2'b01;
   localparam logic [1:0] OUT_AR     = 2'b10;
   localparam logic [1:0] OUT_SP     = 2'b11;

   // MuxA / MuxB sources
   localparam logic [1:0] MUX_ALU  = 2'b00;
   localparam logic [1:0] MUX_OUTC = 2'b01;
   localparam logic [1:0] MUX_MEM  = 2'b10;
   localparam logic [1:0] MUX_IR   = 2'b11;

   // Positions inside FlagsOut = {Z,C,N,O}
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_system_register16.sv
// 16-bit register with the shared eight-function load/count encoding.
// Used for every RF and ARF register.
module register16
   import alu_system_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic [2:0]  i_fun_sel,
   input  logic [15:0] i_data,
   output logic [15:0] o_q
);

   logic [15:0] Q;

   // Apply the selected function when enabled; async clear on rst
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Q <= '0;
      end else if (i_en) begin
         case (i_fun_sel)
            FUN_DEC:     Q <= Q - 16'd1;
            FUN_INC:     Q <= Q + 16'd1;
            FUN_LOAD:    Q <= i_data;
            FUN_CLR:     Q <= '0;
            FUN_LOAD_ZX: Q <= {8'h00, i_data[7:0]};
            FUN_LOAD_LO: Q[7:0] <= i_data[7:0];
            FUN_LOAD_HI: Q[15:8] <= i_data[7:0];
            FUN_LOAD_SX: Q <= {{8{i_data[7]}}, i_data[7:0]};
         endcase
      end
   end

   assign o_q = Q;

endmodule

// File: rtl/alu_system.sv
// Datapath of the teaching CPU: RF, ARF, ALU with flags, IR, byte memory and
// muxes A/B/C. All control arrives on the select/enable inputs.
module alu_system
   import alu_system_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 16
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [2:0]  RF_OutASel,
   input  logic [2:0]  RF_OutBSel,
   input  logic [2:0]  RF_FunSel,
   input  logic [3:0]  RF_RegSel,
   input  logic [3:0]  RF_ScrSel,
   input  logic [4:0]  ALU_FunSel,
   input  logic        ALU_WF,
   input  logic [1:0]  ARF_OutCSel,
   input  logic [1:0]  ARF_OutDSel,
   input  logic [2:0]  ARF_FunSel,
   input  logic [2:0]  ARF_RegSel,
   input  logic        IR_LH,
   input  logic        IR_Write,
   input  logic        Mem_WR,
   input  logic        Mem_CS,
   input  logic [1:0]  MuxASel,
   input  logic [1:0]  MuxBSel,
   input  logic        MuxCSel,
   output logic [15:0] OutA,
   output logic [15:0] OutB,
   output logic [15:0] OutC,
   output logic [15:0] Address,
   output logic [15:0] ALUOut,
   output logic [15:0] MuxAOut,
   output logic [15:0] MuxBOut,
   output logic [15:0] IROut,
   output logic [7:0]  MuxCOut,
   output logic [7:0]  MemOut,
   output logic [3:0]  FlagsOut
);

   // Index 0-3 = R1-R4, 4-7 = S1-S4, matching the OutSel encoding
   logic [15:0] w_rf_q [8];
   logic [15:0] w_pc, w_ar, w_sp;

   register16 R1 (.clk(Clock), .rst(Reset), .i_en(~RF_RegSel[3]), .i_fun_sel(RF_FunSel), .i_data(MuxAOut), .o_q(w_rf_q[0]));
   register16 R2 (.clk(Clock), .rst(Reset), .i_en(~RF_RegSel[2]), .i_fun_sel(RF_FunSel), .i_data(MuxAOut), .o_q(w_rf_q[1]));
   register16 R3 (.clk(Clock), .rst(Reset), .i_en(~RF_RegSel[1]), .i_fun_sel(RF_FunSel), .i_data(MuxAOut), .o_q(w_rf_q[2]));
   register16 R4 (.clk(Clock), .rst(Reset), .i_en(~RF_RegSel[0]), .i_fun_sel(RF_FunSel), .i_data(MuxAOut), .o_q(w_rf_q[3]));
   register16 S1 (.clk(Clock), .rst(Reset), .i_en(~RF_ScrSel[3]), .i_fun_sel(RF_FunSel), .i_data(MuxAOut), .o_q(w_rf_q[4]));
   register16 S2 (.clk(Clock), .rst(Reset), .i_en(~RF_ScrSel[2]), .i_fun_sel(RF_FunSel), .i_data(MuxAOut), .o_q(w_rf_q[5]));
   register16 S3 (.clk(Clock), .rst(Reset), .i_en(~RF_ScrSel[1]), .i_fun_sel(RF_FunSel), .i_data(MuxAOut), .o_q(w_rf_q[6]));
   register16 S4 (.clk(Clock), .rst(Reset), .i_en(~RF_ScrSel[0]), .i_fun_sel(RF_FunSel), .i_data(MuxAOut), .o_q(w_rf_q[7]));

   register16 PC (.clk(Clock), .rst(Reset), .i_en(~ARF_RegSel[2]), .i_fun_sel(ARF_FunSel), .i_data(MuxBOut), .o_q(w_pc));
   register16 AR (.clk(Clock), .rst(Reset), .i_en(~ARF_RegSel[1]), .i_fun_sel(ARF_FunSel), .i_data(MuxBOut), .o_q(w_ar));
   register16 SP (.clk(Clock), .rst(Reset), .i_en(~ARF_RegSel[0]), .i_fun_sel(ARF_FunSel), .i_data(MuxBOut), .o_q(w_sp));

   assign OutA    = w_rf_q[RF_OutASel];
   assign OutB    = w_rf_q[RF_OutBSel];
   assign OutC    = (ARF_OutCSel == OUT_AR) ? w_ar : (ARF_OutCSel == OUT_SP) ? w_sp : w_pc;
   assign Address = (ARF_OutDSel == OUT_AR) ? w_ar : (ARF_OutDSel == OUT_SP) ? w_sp : w_pc;

   // Source selection for the RF (MuxA) and ARF (MuxB) inputs
   // NOTE: every combinational output gets a value on every path, so no latch is inferred.
   always_comb begin
      case (MuxASel)
         MUX_ALU:  MuxAOut = ALUOut;
         MUX_OUTC: MuxAOut = OutC;
         MUX_MEM:  MuxAOut = {8'h00, MemOut};
         default:  MuxAOut = {8'h00, IROut[7:0]};
      endcase
      case (MuxBSel)
         MUX_ALU:  MuxBOut = ALUOut;
         MUX_OUTC: MuxBOut = OutC;
         MUX_MEM:  MuxBOut = {8'h00, MemOut};
         default:  MuxBOut = {8'h00, IROut[7:0]};
      endcase
   end

   assign MuxCOut = MuxCSel ? ALUOut[15:8] : ALUOut[7:0];

   if (1) begin : ALU
      // 8-bit mode aligns the operand byte to bits 15:8 so carry, overflow
      // and N come from bit 15 in both modes; w_lsb marks the window bottom.
      logic [3:0]  r_flags;
      logic        w_wide;
      logic [3:0]  w_lsb;
      logic [15:0] w_a, w_b, w_cin, w_res;
      logic        w_c, w_o;

      assign w_wide = ALU_FunSel[4];
      assign w_lsb  = w_wide ? 4'd0 : 4'd8;
      assign w_a    = w_wide ? OutA : {OutA[7:0], 8'h00};
      assign w_b    = w_wide ? OutB : {OutB[7:0], 8'h00};
      assign w_cin  = w_wide ? {15'h0000, r_flags[FLAG_C]} : {7'h00, r_flags[FLAG_C], 8'h00};

      // Operation result plus C/O; undefined flags keep their stored value
      always_comb begin
         w_res = '0;
         w_c   = r_flags[FLAG_C];
         w_o   = r_flags[FLAG_O];
         case (ALU_FunSel[3:0])
            ALU_A:     w_res = w_a;
            ALU_B:     w_res = w_b;
            ALU_NOT_A: w_res = ~w_a;
            ALU_NOT_B: w_res = ~w_b;
            ALU_ADD: begin
               {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b};
               w_o = (w_a[15] == w_b[15]) && (w_res[15] != w_a[15]);
            end
            ALU_ADC: begin
               {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b} + {1'b0, w_cin};
               w_o = (w_a[15] == w_b[15]) && (w_res[15] != w_a[15]);
            end
            ALU_SUB: begin
               {w_c, w_res} = {1'b0, w_a} + {1'b0, ~w_b} + 17'd1;
               w_o = (w_a[15] != w_b[15]) && (w_res[15] != w_a[15]);
            end
            ALU_AND:   w_res = w_a & w_b;
            ALU_OR:    w_res = w_a | w_b;
            ALU_XOR:   w_res = w_a ^ w_b;
            ALU_NAND:  w_res = ~(w_a & w_b);
            ALU_LSL: begin
               w_c   = w_a[15];
               w_res = w_a << 1;
            end
            ALU_LSR: begin
               w_c   = w_a[w_lsb];
               w_res = w_a >> 1;
            end
            ALU_ASR: begin
               w_c   = w_a[w_lsb];
               w_res = {w_a[15], w_a[15:1]};
            end
            ALU_CSL: begin
               w_c          = w_a[15];
               w_res        = w_a << 1;
               w_res[w_lsb] = w_a[15];
            end
            ALU_CSR: begin
               w_c       = w_a[w_lsb];
               w_res     = w_a >> 1;
               w_res[15] = w_a[w_lsb];
            end
         endcase
      end

      assign ALUOut = w_wide ? w_res : {8'h00, w_res[15:8]};

      // Flags latch only when ALU_WF is set
      always_ff @(posedge Clock or posedge Reset) begin
         if (Reset)       r_flags <= '0;
         else if (ALU_WF) r_flags <= {ALUOut == 16'h0000, w_c, w_res[15], w_o};
      end

      assign FlagsOut = r_flags;
   end

   if (1) begin : IR
      logic [15:0] r_ir;

      // Load one byte of the instruction from memory per write
      always_ff @(posedge Clock or posedge Reset) begin
         if (Reset) begin
            r_ir <= '0;
         end else if (IR_Write) begin
            if (IR_LH) r_ir[15:8] <= MemOut;
            else       r_ir[7:0]  <= MemOut;
         end
      end

      assign IROut = r_ir;
   end

   if (1) begin : MEM
      logic [7:0]                RAM_DATA [2**MEM_ADDR_WIDTH];
      logic [MEM_ADDR_WIDTH-1:0] w_addr;

      assign w_addr = Address[MEM_ADDR_WIDTH-1:0];
      assign MemOut = (!Mem_CS && !Mem_WR) ? RAM_DATA[w_addr] : 8'h00;

      // Byte write of MuxC output when selected for write
      // NOTE: memory array has no reset; contents survive Reset.
      always_ff @(posedge Clock) begin
         if (!Mem_CS && Mem_WR) RAM_DATA[w_addr] <= MuxCOut;
      end
   end

endmodule

// File: tb/tb_alu_system.sv
// Scoreboard bench for alu_system: stimulus pushes expected observations,
// a monitor on the falling edge pops and compares them.
module tb_alu_system;
   import alu_system_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
   logic [3:0]  RF_RegSel, RF_ScrSel;
   logic [4:0]  ALU_FunSel;
   logic        ALU_WF;
   logic [1:0]  ARF_OutCSel, ARF_OutDSel;
   logic [2:0]  ARF_FunSel, ARF_RegSel;
   logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
   logic [1:0]  MuxASel, MuxBSel;
   logic        MuxCSel;
   logic [15:0] OutA, OutB, OutC, Address, ALUOut, MuxAOut, MuxBOut, IROut;
   logic [7:0]  MuxCOut, MemOut;
   logic [3:0]  FlagsOut;

   typedef enum {S_OUTA, S_OUTB, S_OUTC, S_ADDR, S_ALU, S_MUXA, S_MUXB, S_MUXC, S_MEM, S_IR, S_FLAGS} sig_e;
   typedef struct {
      sig_e        sig;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic [2:0]  funs_a [3] = '{FUN_INC, FUN_DEC, FUN_LOAD_SX};
   logic [15:0] vals_a [3] = '{16'h0100, 16'h00FF, 16'hFF80};
   logic [2:0]  funs_b [6] = '{FUN_LOAD_HI, FUN_LOAD_LO, FUN_LOAD_ZX, FUN_CLR, FUN_DEC, FUN_INC};
   logic [15:0] vals_b [6] = '{16'h80FF, 16'h8080, 16'h0080, 16'h0000, 16'hFFFF, 16'h0000};

   alu_system #(.MEM_ADDR_WIDTH(16)) dut (
      .Clock(Clock), .Reset(Reset),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
      .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
      .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
      .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
      .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
      .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
      .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
      .OutA(OutA), .OutB(OutB), .OutC(OutC), .Address(Address),
      .ALUOut(ALUOut), .MuxAOut(MuxAOut), .MuxBOut(MuxBOut), .IROut(IROut),
      .MuxCOut(MuxCOut), .MemOut(MemOut), .FlagsOut(FlagsOut)
   );

   always #5 Clock = ~Clock;

   function automatic logic [15:0] observe(input sig_e s);
      case (s)
         S_OUTA:  return OutA;
         S_OUTB:  return OutB;
         S_OUTC:  return OutC;
         S_ADDR:  return Address;
         S_ALU:   return ALUOut;
         S_MUXA:  return MuxAOut;
         S_MUXB:  return MuxBOut;
         S_MUXC:  return {8'h00, MuxCOut};
         S_MEM:   return {8'h00, MemOut};
         S_IR:    return IROut;
         default: return {12'h000, FlagsOut};
      endcase
   endfunction

   task automatic check(input sig_e s, input logic [15:0] v, input string name);
      exp_t e;
      e.sig  = s;
      e.exp  = v;
      e.name = name;
      sb_q.push_back(e);
   endtask

   // Monitor: outputs are stable at the falling edge
   initial begin : monitor
      exp_t        e;
      logic [15:0] act;
      forever begin
         @(negedge Clock);
         while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = observe(e.sig);
            n_checks++;
            if (act !== e.exp) begin
               n_errors++;
               $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      RF_RegSel  = 4'hF;
      RF_ScrSel  = 4'hF;
      ARF_RegSel = 3'h7;
      IR_Write   = 1'b0;
      Mem_CS     = 1'b1;
      Mem_WR     = 1'b0;
      ALU_WF     = 1'b0;
   endtask

   // Build a value in RF register idx by shift-left / increment, flags untouched
   task automatic set_rf(input int idx, input logic [15:0] val);
      logic [3:0] mask;
      idle();
      mask       = 4'b1000 >> (idx % 4);
      if (idx < 4) RF_RegSel = ~mask;
      else         RF_ScrSel = ~mask;
      RF_OutASel = 3'(idx);
      ALU_FunSel = {1'b1, ALU_LSL};
      MuxASel    = MUX_ALU;
      RF_FunSel  = FUN_CLR;
      tick();
      for (int i = 15; i >= 0; i--) begin
         RF_FunSel = FUN_LOAD;
         tick();
         if (val[i]) begin
            RF_FunSel = FUN_INC;
            tick();
         end
      end
      idle();
   endtask

   // which: 0 PC, 1 AR, 2 SP; value routed S4 -> ALU -> MuxB
   task automatic set_arf(input int which, input logic [15:0] val);
      set_rf(7, val);
      RF_OutASel = 3'd7;
      ALU_FunSel = {1'b1, ALU_A};
      MuxBSel    = MUX_ALU;
      ARF_FunSel = FUN_LOAD;
      ARF_RegSel = ~(3'b100 >> which);
      tick();
      idle();
   endtask

   task automatic write_mem(input logic [15:0] addr, input logic [7:0] data);
      set_arf(1, addr);
      set_rf(7, {8'h00, data});
      RF_OutASel  = 3'd7;
      ALU_FunSel  = {1'b1, ALU_A};
      MuxCSel     = 1'b0;
      ARF_OutDSel = OUT_AR;
      Mem_CS      = 1'b0;
      Mem_WR      = 1'b1;
      tick();
      idle();
   endtask

   initial begin : stimulus
      Reset = 1'b1;
      idle();
      RF_OutASel = 3'd0; RF_OutBSel = 3'd4; RF_FunSel = FUN_LOAD;
      ALU_FunSel = {1'b1, ALU_A};
      ARF_OutCSel = OUT_PC; ARF_OutDSel = OUT_PC_ALT; ARF_FunSel = FUN_LOAD;
      IR_LH = 1'b0; MuxASel = MUX_IR; MuxBSel = MUX_ALU; MuxCSel = 1'b0;
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;

      // Reset state
      check(S_OUTA,  16'h0000, "reset_R1");
      check(S_OUTB,  16'h0000, "reset_S1");
      check(S_OUTC,  16'h0000, "reset_PC");
      check(S_ADDR,  16'h0000, "reset_addr");
      check(S_IR,    16'h0000, "reset_IR");
      check(S_FLAGS, 16'h0000, "reset_flags");
      check(S_MEM,   16'h0000, "reset_memout_cs_off");
      check(S_MUXA,  16'h0000, "reset_muxa_ir");
      tick();

      // 16-bit add-with-carry fanned out to R2, S3 and PC
      set_rf(0, 16'h7777);
      set_rf(5, 16'h8887);
      RF_OutASel = 3'd0; RF_OutBSel = 3'd5; ALU_FunSel = 5'b10101; ALU_WF = 1'b1;
      MuxASel = MUX_ALU; MuxBSel = MUX_ALU; MuxCSel = 1'b0;
      RF_FunSel = FUN_LOAD; ARF_FunSel = FUN_LOAD;
      RF_RegSel = 4'b1011; RF_ScrSel = 4'b1101; ARF_RegSel = 3'b011;
      check(S_ALU,   16'hFFFE, "add16_aluout");
      check(S_MUXC,  16'h00FE, "add16_muxc");
      check(S_FLAGS, 16'h0000, "add16_flags_before");
      tick();
      idle();
      RF_OutASel = 3'd1; RF_OutBSel = 3'd6; ARF_OutCSel = OUT_PC; ARF_OutDSel = OUT_PC_ALT;
      check(S_OUTA,  16'hFFFE, "add16_R2");
      check(S_OUTB,  16'hFFFE, "add16_S3");
      check(S_OUTC,  16'hFFFE, "add16_PC");
      check(S_ADDR,  16'hFFFE, "add16_PC_via_D01");
      check(S_FLAGS, 16'h0002, "add16_flags_after");
      tick();

      // Instruction register load from memory
      write_mem(16'h0023, 8'h15);
      set_arf(0, 16'h1254);
      ARF_OutCSel = OUT_PC; ARF_OutDSel = OUT_AR;
      Mem_CS = 1'b0; Mem_WR = 1'b0; IR_LH = 1'b0; IR_Write = 1'b1; MuxBSel = MUX_MEM;
      check(S_OUTC, 16'h1254, "irload_outc");
      check(S_ADDR, 16'h0023, "irload_addr");
      check(S_MEM,  16'h0015, "irload_memout");
      check(S_MUXB, 16'h0015, "irload_muxb_mem");
      check(S_IR,   16'h0000, "irload_ir_before");
      tick();
      IR_LH = 1'b1;
      check(S_IR, 16'h0015, "irload_ir_low");
      tick();
      idle();
      MuxASel = MUX_IR;
      check(S_IR,   16'h1515, "irload_ir_high");
      check(S_MUXA, 16'h0015, "irload_muxa_ir");
      tick();

      // 16-bit subtract to zero: Z and C set
      set_rf(0, 16'h0010);
      set_rf(1, 16'h0010);
      RF_OutASel = 3'd0; RF_OutBSel = 3'd1; ALU_FunSel = {1'b1, ALU_SUB}; ALU_WF = 1'b1;
      check(S_ALU, 16'h0000, "sub16_aluout");
      tick();
      ALU_WF = 1'b0;
      check(S_FLAGS, 16'h000C, "sub16_flags");

      // 8-bit subtract with borrow
      set_rf(1, 16'h0020);
      RF_OutASel = 3'd0; RF_OutBSel = 3'd1; ALU_FunSel = {1'b0, ALU_SUB}; ALU_WF = 1'b1;
      check(S_ALU, 16'h00F0, "sub8_aluout");
      tick();
      ALU_WF = 1'b0;
      check(S_FLAGS, 16'h0002, "sub8_flags");

      // 8-bit add: carry and overflow out of bit 7, upper bytes ignored
      set_rf(0, 16'h1290);
      set_rf(1, 16'h3490);
      RF_OutASel = 3'd0; RF_OutBSel = 3'd1; ALU_FunSel = {1'b0, ALU_ADD}; ALU_WF = 1'b1;
      check(S_ALU, 16'h0020, "add8_aluout");
      tick();
      ALU_WF = 1'b0;
      check(S_FLAGS, 16'h0005, "add8_flags");

      // 8-bit rotate right: C from bit 0, O held
      set_rf(0, 16'hFF81);
      RF_OutASel = 3'd0; ALU_FunSel = {1'b0, ALU_CSR}; ALU_WF = 1'b1;
      check(S_ALU, 16'h00C0, "csr8_aluout");
      tick();
      ALU_WF = 1'b0;
      check(S_FLAGS, 16'h0007, "csr8_flags");

      // Memory write of ALUOut high byte through MuxC
      set_arf(1, 16'h0040);
      set_rf(0, 16'hABCD);
      RF_OutASel = 3'd0; ALU_FunSel = {1'b1, ALU_A}; MuxCSel = 1'b1; ARF_OutDSel = OUT_AR;
      Mem_CS = 1'b0; Mem_WR = 1'b1;
      check(S_MUXC, 16'h00AB, "memwr_muxc_hi");
      check(S_ADDR, 16'h0040, "memwr_addr");
      check(S_MEM,  16'h0000, "memwr_memout_during_write");
      tick();
      Mem_WR = 1'b0; MuxCSel = 1'b0;
      check(S_MEM,  16'h00AB, "memwr_readback");
      check(S_MUXC, 16'h00CD, "memwr_muxc_lo");
      tick();
      idle();

      // Register functions on R3 with input 0080
      set_rf(0, 16'h0080);
      set_rf(2, 16'h00FF);
      RF_OutASel = 3'd0; RF_OutBSel = 3'd2; ALU_FunSel = {1'b1, ALU_A}; MuxASel = MUX_ALU;
      RF_RegSel = 4'b1101;
      for (int i = 0; i < 3; i++) begin
         RF_FunSel = funs_a[i];
         tick();
         check(S_OUTB, vals_a[i], $sformatf("regfun_a%0d", i));
      end
      set_rf(2, 16'h00FF);
      RF_OutASel = 3'd0; RF_OutBSel = 3'd2; ALU_FunSel = {1'b1, ALU_A}; MuxASel = MUX_ALU;
      RF_RegSel = 4'b1101;
      for (int i = 0; i < 6; i++) begin
         RF_FunSel = funs_b[i];
         tick();
         check(S_OUTB, vals_b[i], $sformatf("regfun_b%0d", i));
      end
      idle();

      // Mid-cycle asynchronous reset with all registers at 5A5A
      set_rf(0, 16'h5A5A);
      RF_OutASel = 3'd0; ALU_FunSel = {1'b1, ALU_A}; MuxASel = MUX_ALU; MuxBSel = MUX_ALU;
      RF_FunSel = FUN_LOAD; ARF_FunSel = FUN_LOAD;
      RF_RegSel = 4'b0000; RF_ScrSel = 4'b0000; ARF_RegSel = 3'b000;
      tick();
      idle();
      RF_OutASel = 3'd3; RF_OutBSel = 3'd7; ARF_OutCSel = OUT_SP; ARF_OutDSel = OUT_AR;
      check(S_OUTA,  16'h5A5A, "prerst_R4");
      check(S_OUTB,  16'h5A5A, "prerst_S4");
      check(S_OUTC,  16'h5A5A, "prerst_SP");
      check(S_ADDR,  16'h5A5A, "prerst_AR");
      check(S_IR,    16'h1515, "prerst_IR");
      check(S_FLAGS, 16'h0007, "prerst_flags");
      @(posedge Clock);
      #2 Reset = 1'b1;
      check(S_OUTA,  16'h0000, "rst_R4");
      check(S_OUTB,  16'h0000, "rst_S4");
      check(S_OUTC,  16'h0000, "rst_SP");
      check(S_ADDR,  16'h0000, "rst_AR");
      check(S_IR,    16'h0000, "rst_IR");
      check(S_FLAGS, 16'h0000, "rst_flags");
      @(negedge Clock);
      #1;
      tick();
      Reset = 1'b0;

      repeat (2) @(negedge Clock);
      #1;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
